branch_unit: RTL and testbench

- Branch/jump resolution unit for the rv32i pipelined core, in the execute stage.
- Compares the two register-unit operands RURs1/RURs2 under control of BrOp and drives NextPCSrc combinationally to the PC-select mux (1 = take target, 0 = PC+4).
- Also keeps registered observability state: last decision, an illegal-encoding flag, and branch/taken event counters for debug and performance.

---
 rtl/branch_unit.sv | 140 ++++++++++++++
 tb/tb_branch_unit.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/branch_unit.sv
// -----------------------------------------------------------------------------
// branch_unit
//
// Branch/jump resolution for the execute stage of the rv32i core. Compares the
// two register-unit operands under control of BrOp and produces the PC-select
// decision combinationally. It also keeps a small set of registered
// observability state for debug and performance monitoring.
//
// Ports:
//   clk          in   1      clock; used only by the observability registers
//   rst          in   1      asynchronous active-high reset of those registers
//   RURs1        in   XLEN   operand A (rs1), signed view for BLT/BGE
//   RURs2        in   XLEN   operand B (rs2)
//   BrOp         in   5      [4] jump, [3] conditional branch, [2:0] funct3
//   NextPCSrc    out  1      1 = redirect to target, 0 = PC+4 (combinational)
//   BrIllegal    out  1      conditional branch with reserved funct3 (comb.)
//   LastTaken    out  1      NextPCSrc registered from the previous cycle
//   BranchCount  out  CNT_W  saturating count of cycles with a jump or branch
//   TakenCount   out  CNT_W  saturating count of cycles with NextPCSrc = 1
// -----------------------------------------------------------------------------
module branch_unit #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [XLEN-1:0]  RURs1,
    input  logic [XLEN-1:0]  RURs2,
    input  logic [4:0]       BrOp,
    output logic             NextPCSrc,
    output logic             BrIllegal,
    output logic             LastTaken,
    output logic [CNT_W-1:0] BranchCount,
    output logic [CNT_W-1:0] TakenCount
);

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    // Increment by one when enabled, holding at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] val,
                                                 input logic             en);
        logic [CNT_W-1:0] res;
        res = val;
        if (en && !(&val)) begin
            res = val + CNT_ONE;
        end
        return res;
    endfunction

    // Signed views of the operands; bit XLEN-1 is the sign, no extension.
    logic signed [XLEN-1:0] rs1_s;
    logic signed [XLEN-1:0] rs2_s;

    logic is_jump;
    logic is_branch;
    logic [2:0] funct3;

    logic cmp_eq;
    logic cmp_lt_s;
    logic cmp_lt_u;

    logic take;
    logic illegal;

    assign rs1_s     = RURs1;
    assign rs2_s     = RURs2;
    assign is_jump   = BrOp[4];
    assign is_branch = BrOp[3];
    assign funct3    = BrOp[2:0];

    assign cmp_eq   = (RURs1 == RURs2);
    assign cmp_lt_s = (rs1_s < rs2_s);
    assign cmp_lt_u = (RURs1 < RURs2);

    // Decision: jump has priority over any conditional encoding.
    always_comb begin
        take    = 1'b0;
        illegal = 1'b0;
        if (is_jump) begin
            take = 1'b1;
        end else if (is_branch) begin
            case (funct3)
                F3_BEQ:  take = cmp_eq;
                F3_BNE:  take = !cmp_eq;
                F3_BLT:  take = cmp_lt_s;
                F3_BGE:  take = !cmp_lt_s;
                F3_BLTU: take = cmp_lt_u;
                F3_BGEU: take = !cmp_lt_u;
                default: begin
                    // 010/011 are reserved: never redirect, flag it instead.
                    take    = 1'b0;
                    illegal = 1'b1;
                end
            endcase
        end
    end

    assign NextPCSrc = take;
    assign BrIllegal = illegal;

    // -------------------------------------------------------------------------
    // Observability registers
    // -------------------------------------------------------------------------
    logic             last_taken_d;
    logic             last_taken_q;
    logic [CNT_W-1:0] branch_cnt_d;
    logic [CNT_W-1:0] branch_cnt_q;
    logic [CNT_W-1:0] taken_cnt_d;
    logic [CNT_W-1:0] taken_cnt_q;

    always_comb begin
        last_taken_d = take;
        branch_cnt_d = sat_inc(branch_cnt_q, is_jump | is_branch);
        taken_cnt_d  = sat_inc(taken_cnt_q, take);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_taken_q <= 1'b0;
            branch_cnt_q <= '0;
            taken_cnt_q  <= '0;
        end else begin
            last_taken_q <= last_taken_d;
            branch_cnt_q <= branch_cnt_d;
            taken_cnt_q  <= taken_cnt_d;
        end
    end

    assign LastTaken   = last_taken_q;
    assign BranchCount = branch_cnt_q;
    assign TakenCount  = taken_cnt_q;

endmodule

// File: tb/tb_branch_unit.sv
// -----------------------------------------------------------------------------
// tb_branch_unit
//
// Self-checking bench for branch_unit. Directed cases from the decode rules,
// then randomized traffic checked against a behavioural model. The DUT is
// built with an 8-bit counter so counter saturation is reachable quickly.
// -----------------------------------------------------------------------------
module tb_branch_unit;

    localparam int XLEN  = 32;
    localparam int CNT_W = 8;
    localparam longint CNT_MAX = (64'd1 << CNT_W) - 1;

    logic             clk;
    logic             rst;
    logic [XLEN-1:0]  rurs1;
    logic [XLEN-1:0]  rurs2;
    logic [4:0]       br_op;
    logic             next_pc_src;
    logic             br_illegal;
    logic             last_taken;
    logic [CNT_W-1:0] branch_count;
    logic [CNT_W-1:0] taken_count;

    int n_tests;
    int n_fail;

    // Reference state for the registered outputs.
    logic   exp_last;
    longint exp_bc;
    longint exp_tc;

    branch_unit #(
        .XLEN  (XLEN),
        .CNT_W (CNT_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .RURs1       (rurs1),
        .RURs2       (rurs2),
        .BrOp        (br_op),
        .NextPCSrc   (next_pc_src),
        .BrIllegal   (br_illegal),
        .LastTaken   (last_taken),
        .BranchCount (branch_count),
        .TakenCount  (taken_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got,
                            input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Decision straight from the ISA rules, using integer arithmetic.
    function automatic logic ref_taken(input logic [4:0] op,
                                       input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, ua, ub;
        sa = (a >= 32'h8000_0000) ? longint'(a) - 64'sd4294967296 : longint'(a);
        sb = (b >= 32'h8000_0000) ? longint'(b) - 64'sd4294967296 : longint'(b);
        ua = longint'(a);
        ub = longint'(b);
        if (op[4]) return 1'b1;
        if (!op[3]) return 1'b0;
        case (op[2:0])
            3'd0: return ua == ub;
            3'd1: return ua != ub;
            3'd4: return sa < sb;
            3'd5: return sa >= sb;
            3'd6: return ua < ub;
            3'd7: return ua >= ub;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic ref_illegal(input logic [4:0] op);
        return !op[4] && op[3] && (op[2:0] == 3'd2 || op[2:0] == 3'd3);
    endfunction

    task automatic model_clear();
        exp_last = 1'b0;
        exp_bc   = 0;
        exp_tc   = 0;
    endtask

    task automatic check_regs(input string tag);
        check_eq({tag, ".last"}, 64'(last_taken), 64'(exp_last));
        check_eq({tag, ".bc"}, 64'(branch_count), 64'(exp_bc));
        check_eq({tag, ".tc"}, 64'(taken_count), 64'(exp_tc));
    endtask

    // Apply one operation for one clock: check the combinational outputs
    // before the edge and the registered state just after it.
    task automatic step(input string tag, input logic [4:0] op,
                        input logic [31:0] a, input logic [31:0] b);
        logic t;
        br_op = op;
        rurs1 = a;
        rurs2 = b;
        #1;
        t = ref_taken(op, a, b);
        check_eq({tag, ".npc"}, 64'(next_pc_src), 64'(t));
        check_eq({tag, ".ill"}, 64'(br_illegal), 64'(ref_illegal(op)));
        @(posedge clk);
        exp_last = t;
        if (op[4] | op[3]) exp_bc = (exp_bc < CNT_MAX) ? exp_bc + 1 : CNT_MAX;
        if (t) exp_tc = (exp_tc < CNT_MAX) ? exp_tc + 1 : CNT_MAX;
        #1;
        check_regs(tag);
    endtask

    // Combinational-only probe with a fixed expected value.
    task automatic comb(input string tag, input logic [4:0] op,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic exp_npc, input logic exp_ill);
        br_op = op;
        rurs1 = a;
        rurs2 = b;
        #1;
        check_eq({tag, ".npc"}, 64'(next_pc_src), 64'(exp_npc));
        check_eq({tag, ".ill"}, 64'(br_illegal), 64'(exp_ill));
    endtask

    function automatic logic [31:0] rand_operand();
        case ($urandom_range(0, 4))
            0: return 32'h8000_0000;
            1: return 32'h7FFF_FFFF;
            2: return 32'($urandom_range(0, 7));
            3: return 32'hFFFF_FFFF - 32'($urandom_range(0, 3));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        logic [31:0] a;
        logic [31:0] b;
        n_tests = 0;
        n_fail  = 0;
        rst   = 1'b1;
        rurs1 = '0;
        rurs2 = '0;
        br_op = '0;
        model_clear();
        @(posedge clk);
        #1;
        check_regs("reset");

        // Directed decode cases; reset is held so only comb outputs matter.
        comb("beq_eq",   5'b01000, 32'd10, 32'd10, 1'b1, 1'b0);
        comb("beq_ne",   5'b01000, 32'd10, 32'd20, 1'b0, 1'b0);
        comb("jump",     5'b10000, 32'd10, 32'd20, 1'b1, 1'b0);
        comb("jump_pri", 5'b11001, 32'd7,  32'd7,  1'b1, 1'b0);
        comb("blt_edge", 5'b01100, 32'h8000_0000, 32'h7FFF_FFFF, 1'b1, 1'b0);
        comb("bltu_edge",5'b01110, 32'h8000_0000, 32'h7FFF_FFFF, 1'b0, 1'b0);
        comb("bgeu_edge",5'b01111, 32'h8000_0000, 32'h7FFF_FFFF, 1'b1, 1'b0);
        comb("bge_edge", 5'b01101, 32'h8000_0000, 32'h7FFF_FFFF, 1'b0, 1'b0);
        comb("bge_eq",   5'b01101, 32'd5, 32'd5, 1'b1, 1'b0);
        comb("bgeu_eq",  5'b01111, 32'd5, 32'd5, 1'b1, 1'b0);
        comb("blt_eq",   5'b01100, 32'd5, 32'd5, 1'b0, 1'b0);
        comb("bltu_eq",  5'b01110, 32'd5, 32'd5, 1'b0, 1'b0);
        comb("bne",      5'b01001, 32'd3, 32'd4, 1'b1, 1'b0);
        comb("rsv010",   5'b01010, 32'd3, 32'd4, 1'b0, 1'b1);
        comb("rsv011",   5'b01011, 32'd3, 32'd3, 1'b0, 1'b1);
        comb("nobr",     5'b00111, 32'd3, 32'd4, 1'b0, 1'b0);
        comb("jmp_rsv",  5'b11010, 32'd3, 32'd4, 1'b1, 1'b0);
        check_regs("rst_held");

        // Counter sequence from a clean reset.
        @(negedge clk);
        rst = 1'b0;
        step("seq0", 5'b01000, 32'd10, 32'd10);
        step("seq1", 5'b01000, 32'd10, 32'd20);
        step("seq2", 5'b10000, 32'd10, 32'd20);
        step("seq3", 5'b00000, 32'd10, 32'd10);
        check_eq("seq.bc", 64'(branch_count), 64'd3);
        check_eq("seq.tc", 64'(taken_count), 64'd2);
        check_eq("seq.last", 64'(last_taken), 64'd0);
        step("rsv_cnt", 5'b01011, 32'd1, 32'd2);
        check_eq("rsv_cnt.bc", 64'(branch_count), 64'd4);
        check_eq("rsv_cnt.tc", 64'(taken_count), 64'd2);

        // Asynchronous reset between edges; decision keeps tracking inputs.
        step("pre_rst", 5'b10000, 32'd0, 32'd0);
        #2;
        rst = 1'b1;
        #1;
        model_clear();
        check_regs("async_rst");
        comb("rst_track1", 5'b01001, 32'd1, 32'd2, 1'b1, 1'b0);
        comb("rst_track2", 5'b01001, 32'd2, 32'd2, 1'b0, 1'b0);
        br_op = 5'b10000;
        @(posedge clk);
        #1;
        check_regs("rst_hold_edge");
        @(negedge clk);
        rst = 1'b0;
        step("resume", 5'b10000, 32'd0, 32'd0);
        check_eq("resume.bc", 64'(branch_count), 64'd1);

        // Randomized traffic against the model.
        for (int i = 0; i < 300; i++) begin
            a = rand_operand();
            b = ($urandom_range(0, 3) == 0) ? a : rand_operand();
            step("rand", 5'($urandom_range(0, 31)), a, b);
        end

        // Drive jumps until both counters must have pinned at all-ones.
        for (int i = 0; i < 270; i++) begin
            step("sat", 5'b10000, 32'd0, 32'd1);
        end
        check_eq("sat.bc", 64'(branch_count), 64'(CNT_MAX));
        check_eq("sat.tc", 64'(taken_count), 64'(CNT_MAX));
        step("sat_hold", 5'b11000, 32'd4, 32'd4);
        check_eq("sat_hold.bc", 64'(branch_count), 64'(CNT_MAX));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Global time bound so the bench can never hang.
    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
